// File: rtl/ber_sync_ctrl_pkg.sv
// ber_sync_ctrl_pkg: shared states and defaults; BER_EARLY_LOCK_EN locks on the first zero-error window
package ber_sync_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, LOCK} state_t;
    localparam int OS_DEF       = 4;
    localparam int PRBS_LEN_DEF = 511;
    localparam int WINDOW_DEF   = 511;
    localparam int LOCK_THR_DEF = 64;
    localparam int NB_COUNT_DEF = 64;
`ifdef BER_EARLY_LOCK_EN
    localparam bit EARLY_LOCK = 1'b1;
`else
    localparam bit EARLY_LOCK = 1'b0;
`endif
endpackage

// File: rtl/ber_sync_ctrl_ref_delay_line.sv
// ber_sync_ctrl_ref_delay_line: PRBS reference shift register with selectable tap
module ber_sync_ctrl_ref_delay_line
    import ber_sync_ctrl_pkg::*;
#(
    parameter int PRBS_LEN = PRBS_LEN_DEF,
    parameter int NB_DELAY = 9
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_ref_bit,
    input  logic [NB_DELAY-1:0] i_delay,
    output logic                o_ref_bit
);
    logic [PRBS_LEN-1:0] ref_sr;

    always_ff @(posedge clock) begin
        if (!i_reset)
            ref_sr <= '0;
        else if (i_valid)
            ref_sr <= {ref_sr[PRBS_LEN-2:0], i_ref_bit};
    end

    assign o_ref_bit = ref_sr[i_delay];
endmodule

// File: rtl/ber_sync_ctrl.sv
// ber_sync_ctrl: sweeps (offset, delay) pairs, locks on minimum BER, monitors lock (BER_EARLY_LOCK_EN optional)
module ber_sync_ctrl
    import ber_sync_ctrl_pkg::*;
#(
    parameter int OS        = OS_DEF,
    parameter int NB_OFFSET = 2,
    parameter int PRBS_LEN  = PRBS_LEN_DEF,
    parameter int NB_DELAY  = 9,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int NB_WIN    = 10,
    parameter int LOCK_THR  = LOCK_THR_DEF,
    parameter int NB_COUNT  = NB_COUNT_DEF
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic                 i_rx_bit,
    input  logic                 i_ref_bit,
    output logic [NB_OFFSET-1:0] o_offset,
    output logic [NB_DELAY-1:0]  o_delay,
    output logic                 o_locked,
    output logic [NB_COUNT-1:0]  o_bit_count,
    output logic [NB_COUNT-1:0]  o_error_count
);
    state_t                state, state_nxt;
    logic [NB_OFFSET-1:0]  offset_nxt, best_off, best_off_nxt;
    logic [NB_DELAY-1:0]   delay_nxt, best_dly, best_dly_nxt;
    logic [NB_WIN-1:0]     win_cnt, win_cnt_nxt, win_err, win_err_nxt, best_err, best_err_nxt;
    logic [NB_COUNT-1:0]   bit_nxt, err_nxt;
    logic                  primed, primed_nxt, restart, ref_bit;

    ber_sync_ctrl_ref_delay_line #(.PRBS_LEN(PRBS_LEN), .NB_DELAY(NB_DELAY)) u_ref (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_ref_bit (i_ref_bit),
        .i_delay   (o_delay),
        .o_ref_bit (ref_bit)
    );

    wire                err        = i_rx_bit ^ ref_bit;
    wire [NB_WIN-1:0]   win_sum    = win_err + NB_WIN'(err);
    wire                win_end    = win_cnt == NB_WIN'(WINDOW - 1);
    wire                delay_wrap = o_delay == NB_DELAY'(PRBS_LEN - 1);
    wire                last_pair  = delay_wrap && o_offset == NB_OFFSET'(OS - 1);
    wire                better     = win_sum < best_err;
    wire [NB_WIN-1:0]   cnt_step   = win_end ? '0 : win_cnt + NB_WIN'(1);
    wire [NB_WIN-1:0]   sum_step   = win_end ? '0 : win_sum;

    always_comb begin
        state_nxt    = state;
        offset_nxt   = o_offset;
        delay_nxt    = o_delay;
        best_off_nxt = best_off;
        best_dly_nxt = best_dly;
        best_err_nxt = best_err;
        win_cnt_nxt  = win_cnt;
        win_err_nxt  = win_err;
        primed_nxt   = primed;
        bit_nxt      = o_bit_count;
        err_nxt      = o_error_count;
        restart      = 1'b0;
        if (!i_enable)
            state_nxt = IDLE;
        else begin
            unique case (state)
                IDLE:    restart = 1'b1;
                SETTLE:  if (i_valid) begin
                    state_nxt   = MEASURE;
                    win_cnt_nxt = '0;
                    win_err_nxt = '0;
                end
                MEASURE: if (i_valid) begin
                    win_cnt_nxt = cnt_step;
                    win_err_nxt = sum_step;
                    if (win_end) begin
                        best_off_nxt = better ? o_offset : best_off;
                        best_dly_nxt = better ? o_delay : best_dly;
                        best_err_nxt = better ? win_sum : best_err;
                        if ((EARLY_LOCK && win_sum == '0) || last_pair) begin
                            state_nxt  = LOCK;
                            offset_nxt = best_off_nxt;
                            delay_nxt  = best_dly_nxt;
                            primed_nxt = 1'b0;
                            bit_nxt    = '0;
                            err_nxt    = '0;
                        end else begin
                            state_nxt  = SETTLE;
                            delay_nxt  = delay_wrap ? '0 : o_delay + NB_DELAY'(1);
                            offset_nxt = delay_wrap ? o_offset + NB_OFFSET'(1) : o_offset;
                        end
                    end
                end
                LOCK:    if (i_valid) begin
                    // the first strobe after a pair change is discarded
                    primed_nxt = 1'b1;
                    if (primed) begin
                        bit_nxt     = &o_bit_count ? o_bit_count : o_bit_count + NB_COUNT'(1);
                        err_nxt     = (&o_error_count || !err) ? o_error_count : o_error_count + NB_COUNT'(1);
                        win_cnt_nxt = cnt_step;
                        win_err_nxt = sum_step;
                        restart     = win_end && win_sum > NB_WIN'(LOCK_THR);
                    end
                end
            endcase
        end
        if (restart) begin
            state_nxt    = SETTLE;
            offset_nxt   = '0;
            delay_nxt    = '0;
            best_off_nxt = '0;
            best_dly_nxt = '0;
            best_err_nxt = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            state         <= IDLE;
            o_offset      <= '0;
            o_delay       <= '0;
            o_locked      <= 1'b0;
            o_bit_count   <= '0;
            o_error_count <= '0;
            best_off      <= '0;
            best_dly      <= '0;
            best_err      <= '1;
            win_cnt       <= '0;
            win_err       <= '0;
            primed        <= 1'b0;
        end else begin
            state         <= state_nxt;
            o_offset      <= offset_nxt;
            o_delay       <= delay_nxt;
            o_locked      <= state_nxt == LOCK;
            o_bit_count   <= bit_nxt;
            o_error_count <= err_nxt;
            best_off      <= best_off_nxt;
            best_dly      <= best_dly_nxt;
            best_err      <= best_err_nxt;
            win_cnt       <= win_cnt_nxt;
            win_err       <= win_err_nxt;
            primed        <= primed_nxt;
        end
    end
endmodule

// File: tb/tb_ber_sync_ctrl.sv
// tb_ber_sync_ctrl: scaled-down sweep (31 delays, 63-symbol windows) against a pair-error/argmin reference model
module tb_ber_sync_ctrl;
    localparam int OS = 4, NB_OFF = 2, PL = 31, NB_DLY = 5, W = 63, NB_WIN = 7, THR = 16;
    localparam int NPAIR = OS * PL, SWEEP = NPAIR * (W + 1);
`ifdef BER_EARLY_LOCK_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clock = 1'b0, i_reset = 1'b0, i_enable = 1'b0, i_valid = 1'b0, i_rx_bit = 1'b0, i_ref_bit = 1'b0;
    logic [NB_OFF-1:0] o_offset, s_offset;
    logic [NB_DLY-1:0] o_delay, s_delay;
    logic              o_locked, s_locked;
    logic [63:0]       o_bit_count, o_error_count;
    logic [7:0]        s_bit_count, s_error_count;

    always #5 clock = ~clock;

    ber_sync_ctrl #(.OS(OS), .NB_OFFSET(NB_OFF), .PRBS_LEN(PL), .NB_DELAY(NB_DLY), .WINDOW(W),
                    .NB_WIN(NB_WIN), .LOCK_THR(THR), .NB_COUNT(64)) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .o_offset(o_offset), .o_delay(o_delay),
        .o_locked(o_locked), .o_bit_count(o_bit_count), .o_error_count(o_error_count));

    // narrow-counter copy exposes saturation within a short run
    ber_sync_ctrl #(.OS(OS), .NB_OFFSET(NB_OFF), .PRBS_LEN(PL), .NB_DELAY(NB_DLY), .WINDOW(W),
                    .NB_WIN(NB_WIN), .LOCK_THR(THR), .NB_COUNT(8)) u_sat (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .o_offset(s_offset), .o_delay(s_delay),
        .o_locked(s_locked), .o_bit_count(s_bit_count), .o_error_count(s_error_count));

    int n_tests = 0, n_fail = 0;
    bit ref_h[$];
    int mode, m_k, m_lk, m_win, m_off, m_dly;
    int pair_err[NPAIR];
    bit m_locked;
    longint m_bits, m_errs;
    int ch_mode = 0, ch_d = 17;
    bit [8:0] lfsr = 9'h1FF;

    typedef struct { int n; int off; int dly; bit lck; } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit refat(input int i);
        return (i < 0) ? 1'b0 : ref_h[i];
    endfunction

    function automatic void start_sweep();
        mode = 1; m_k = 0; m_off = 0; m_dly = 0; m_locked = 0;
        foreach (pair_err[i]) pair_err[i] = 0;
    endfunction

    function automatic void lock_on(input int s);
        mode = 2; m_off = s / PL; m_dly = s % PL; m_locked = 1;
        m_bits = 0; m_errs = 0; m_lk = 0; m_win = 0;
    endfunction

    function automatic void model_reset();
        ref_h.delete();
        mode = 0; m_off = 0; m_dly = 0; m_locked = 0; m_bits = 0; m_errs = 0;
    endfunction

    function automatic void model_step(input bit rx, input bit rf);
        int g = ref_h.size();
        if (mode == 1) begin
            int s = m_k / (W + 1);
            int j = m_k % (W + 1);
            if (j > 0) pair_err[s] += int'(rx ^ refat(g - 1 - s % PL));
            m_k++;
            if (j == W) begin
                if (EARLY && pair_err[s] == 0) lock_on(s);
                else if (s == NPAIR - 1) begin
                    int b = 0;
                    for (int p = 1; p < NPAIR; p++) if (pair_err[p] < pair_err[b]) b = p;
                    lock_on(b);
                end else begin
                    m_off = (s + 1) / PL;
                    m_dly = (s + 1) % PL;
                end
            end
        end else if (mode == 2) begin
            bit e = rx ^ refat(g - 1 - m_dly);
            if (m_lk > 0) begin
                m_bits++; m_errs += e; m_win += int'(e);
                if (m_lk % W == 0) begin
                    if (m_win > THR) start_sweep();
                    m_win = 0;
                end
            end
            m_lk++;
        end
        ref_h.push_back(rf);
    endfunction

    task automatic sym(input bit flip);
        bit rx, rf;
        int g;
        if ($urandom_range(7) == 0) @(negedge clock);
        g  = ref_h.size();
        rf = (ch_mode == 1) ? 1'b0 : lfsr[8];
        if (ch_mode != 1) lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        case (ch_mode)
            0:       rx = (m_off == 2) ? refat(g - 1 - ch_d) : bit'($urandom_range(1));
            1:       rx = 1'b0;
            default: rx = refat(g - 1);
        endcase
        rx = rx ^ flip;
        i_valid = 1'b1; i_rx_bit = rx; i_ref_bit = rf;
        @(negedge clock);
        i_valid = 1'b0;
        model_step(rx, rf);
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) sym(period > 0 && (i % period) == period - 1);
    endtask

    task automatic enable_on();
        i_enable = 1'b1;
        @(negedge clock);
        start_sweep();
    endtask

    task automatic enable_off();
        i_enable = 1'b0;
        @(negedge clock);
        mode = 0; m_locked = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_off"}, o_offset, 0);
        chk({tag, "_dly"}, o_delay, 0);
        chk({tag, "_lck"}, o_locked, 0);
        chk({tag, "_bits"}, o_bit_count, 0);
        chk({tag, "_errs"}, o_error_count, 0);
        chk({tag, "_sat_bits"}, s_bit_count, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done = 0, fd = 0, fm = 0, nl = 0;
        tbl.push_back(vec_t'{1, 0, 0, 1'b0});
        tbl.push_back(vec_t'{64, 0, 1, 1'b0});
        tbl.push_back(vec_t'{1984, 1, 0, 1'b0});
        tbl.push_back(vec_t'{3072, 1, 17, 1'b0});
        tbl.push_back(vec_t'{5119, 2, 17, 1'b0});
`ifdef BER_EARLY_LOCK_EN
        tbl.push_back(vec_t'{5120, 2, 17, 1'b1});
`else
        tbl.push_back(vec_t'{5120, 2, 18, 1'b0});
        tbl.push_back(vec_t'{7935, 3, 30, 1'b0});
        tbl.push_back(vec_t'{7936, 2, 17, 1'b1});
`endif
        repeat (2) @(negedge clock);
        chk_zero("reset");
        i_reset = 1'b1;
        model_reset();

        // acquisition: rx is the reference delayed 17 only at offset 2
        enable_on();
        foreach (tbl[i]) begin
            run(tbl[i].n - done, 0);
            done = tbl[i].n;
            chk($sformatf("acq_off[%0d]", i), o_offset, tbl[i].off);
            chk($sformatf("acq_dly[%0d]", i), o_delay, tbl[i].dly);
            chk($sformatf("acq_lck[%0d]", i), o_locked, tbl[i].lck);
        end
        chk("acq_model_off", o_offset, m_off);
        chk("acq_model_dly", o_delay, m_dly);

        run(10001, 0);
        chk("lock_bits", o_bit_count, 10000);
        chk("lock_errs", o_error_count, 0);
        chk("lock_sat_bits", s_bit_count, 255);
        chk("lock_model_bits", o_bit_count, m_bits);

        run(10000, 1000);
        chk("inj_bits", o_bit_count, 20000);
        chk("inj_errs", o_error_count, 10);
        chk("inj_lck", o_locked, 1);
        chk("inj_sat_errs", s_error_count, 10);
        chk("inj_model_errs", o_error_count, m_errs);

        // loss of lock: the channel delay moves to 25
        ch_d = 25;
        for (int n = 1; n <= 2 * W + 1 && (fd == 0 || fm == 0); n++) begin
            sym(1'b0);
            if (!m_locked && fm == 0) fm = n;
            if (!o_locked && fd == 0) fd = n;
        end
        chk("loss_sym", fd, fm);
        chk("loss_in_bound", longint'(fd > 0 && fd <= 2 * W + 1), 1);
        chk("loss_off", o_offset, 0);
        chk("loss_dly", o_delay, 0);
        chk("loss_hold_bits", o_bit_count, m_bits);
        chk("loss_hold_errs", o_error_count, m_errs);
        for (int n = 0; n < SWEEP + 8 && !m_locked; n++) sym(1'b0);
        chk("relock_lck", o_locked, 1);
        chk("relock_off", o_offset, 2);
        chk("relock_dly", o_delay, 25);
        chk("relock_bits", o_bit_count, 0);
        chk("relock_errs", o_error_count, 0);

        run(50, 0);
        chk("pre_dis_bits", o_bit_count, 49);
        enable_off();
        chk("dis_lck", o_locked, 0);
        chk("dis_hold_bits", o_bit_count, 49);
        repeat (5) @(negedge clock);
        chk("dis_hold_bits2", o_bit_count, m_bits);
        enable_on();
        chk("reen_off", o_offset, 0);
        chk("reen_dly", o_delay, 0);
        chk("reen_lck", o_locked, 0);
        run(200, 0);
        chk("resweep_off", o_offset, 0);
        chk("resweep_dly", o_delay, 3);
        chk("resweep_model_dly", o_delay, m_dly);
        enable_off();
        chk("midsweep_dis_lck", o_locked, 0);

        // tie: every pair sees zero errors, earliest pair wins
        i_reset = 1'b0;
        @(negedge clock);
        chk_zero("reset2");
        i_reset = 1'b1;
        model_reset();
        ch_mode = 1;
        enable_on();
        for (int n = 0; n < SWEEP + 8 && !m_locked; n++) sym(1'b0);
        chk("tie_lck", o_locked, 1);
        chk("tie_off", o_offset, 0);
        chk("tie_dly", o_delay, 0);
        run(21, 0);
        chk("tie_bits", o_bit_count, 20);
        i_reset = 1'b0;
        @(negedge clock);
        chk_zero("lock_reset");
        i_reset = 1'b1;
        model_reset();

        // rx equals the undelayed reference at every offset
        ch_mode = 2;
        enable_on();
        for (int n = 1; n <= SWEEP + 8; n++) begin
            sym(1'b0);
            if (o_locked) begin
                nl = n;
                break;
            end
        end
        chk("early_latency", nl, EARLY ? W + 1 : SWEEP);
        chk("early_model_lck", o_locked, m_locked);
        chk("early_off", o_offset, 0);
        chk("early_dly", o_delay, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
